// File: rtl/rsa_montgomery_radix_if.sv
// Operand/result handshake bundle for the radix Montgomery multiplier.
// The slave modport is the multiplier side; the master modport is the requester side.
interface rsa_montgomery_radix_if #(
  parameter int MOD_WIDTH = 256
);
  logic                 i_valid;
  logic                 i_ready;
  logic [MOD_WIDTH-1:0] i_a;
  logic [MOD_WIDTH-1:0] i_b;
  logic [MOD_WIDTH-1:0] i_modulus;
  logic                 o_valid;
  logic                 o_ready;
  logic [MOD_WIDTH-1:0] o_out;
  logic                 o_err;

  modport master (
    output i_valid, i_a, i_b, i_modulus, o_ready,
    input  i_ready, o_valid, o_out, o_err
  );

  modport slave (
    input  i_valid, i_a, i_b, i_modulus, o_ready,
    output i_ready, o_valid, o_out, o_err
  );
endinterface

// File: rtl/rsa_montgomery_radix.sv
// Iterative Montgomery multiplier: out = a*b*2^-MOD_WIDTH mod N, BITS_PER_CYCLE bits per clock.
// Optional operand checking (odd N, a<N, b<N) is enabled by defining RSA_MONT_INPUT_CHECK_EN.
module rsa_montgomery_radix #(
  parameter int MOD_WIDTH      = 256,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rsa_montgomery_radix_if.slave mul_if
);

  localparam int AW = MOD_WIDTH + 2;
  localparam int L  = MOD_WIDTH / BITS_PER_CYCLE;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, LOOP, REDUCE, DONE} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         a_q, a_d;
  logic [AW-1:0]         b_q, b_d;
  logic [AW-1:0]         n_q, n_d;
  logic [AW-1:0]         r_q, r_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [MOD_WIDTH-1:0]  out_q, out_d;
  logic                  accept;
  logic                  chk_fail;
  logic [AW-1:0]         r_step;
  logic                  ready_c;
  logic                  valid_c;

  assign accept = (state_q == IDLE) && mul_if.i_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_if.i_valid) state_d = chk_fail ? DONE : LOOP;
      LOOP:    if (cnt_q == CW'(L - 1)) state_d = REDUCE;
      REDUCE:  state_d = DONE;
      DONE:    if (mul_if.o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_c = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      IDLE:    ready_c = 1'b1;
      DONE:    valid_c = 1'b1;
      default: begin
        ready_c = 1'b0;
        valid_c = 1'b0;
      end
    endcase
  end

  assign mul_if.i_ready = ready_c;
  assign mul_if.o_valid = valid_c;
  assign mul_if.o_out   = out_q;

  // Chained radix-2 sub-steps; r stays below 2N after each shift, so r+b+N < 4N fits in AW bits.
  always_comb begin
    r_step = r_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (a_q[k]) r_step = r_step + b_q;
      if (r_step[0]) r_step = r_step + n_q;
      r_step = r_step >> 1;
    end
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    n_d   = n_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    out_d = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = {2'b00, mul_if.i_a};
          b_d   = {2'b00, mul_if.i_b};
          n_d   = {2'b00, mul_if.i_modulus};
          r_d   = '0;
          cnt_d = '0;
          if (chk_fail) out_d = '0;
        end
      end
      LOOP: begin
        r_d   = r_step;
        a_d   = a_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + CW'(1);
      end
      REDUCE: begin
        out_d = (r_q >= n_q) ? MOD_WIDTH'(r_q - n_q) : r_q[MOD_WIDTH-1:0];
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      n_q   <= n_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

`ifdef RSA_MONT_INPUT_CHECK_EN
  logic err_q, err_d;

  // A rejected request bypasses the loop and is reported as a zero result with the error flag.
  assign chk_fail = ~mul_if.i_modulus[0]
                  | (mul_if.i_a >= mul_if.i_modulus)
                  | (mul_if.i_b >= mul_if.i_modulus);

  always_comb begin
    err_d = err_q;
    if (accept) err_d = chk_fail;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mul_if.o_err = err_q;
`else
  assign chk_fail     = 1'b0;
  assign mul_if.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_montgomery_radix.sv
// Bench for rsa_montgomery_radix: directed 4-bit vectors at radix 2 and 4, stall/reset
// sequences, and random 256-bit radix-16 operations checked by a modular-congruence model.
module tb_rsa_montgomery_radix;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rsa_montgomery_radix_if #(.MOD_WIDTH(4))   if1 ();
  rsa_montgomery_radix_if #(.MOD_WIDTH(4))   if2 ();
  rsa_montgomery_radix_if #(.MOD_WIDTH(256)) if3 ();

  rsa_montgomery_radix #(.MOD_WIDTH(4), .BITS_PER_CYCLE(1)) u_w4_b1 (
    .clk(clk), .rst(rst), .mul_if(if1)
  );
  rsa_montgomery_radix #(.MOD_WIDTH(4), .BITS_PER_CYCLE(2)) u_w4_b2 (
    .clk(clk), .rst(rst), .mul_if(if2)
  );
  rsa_montgomery_radix #(.MOD_WIDTH(256), .BITS_PER_CYCLE(4)) u_w256_b4 (
    .clk(clk), .rst(rst), .mul_if(if3)
  );

  int checks   = 0;
  int failures = 0;

  logic       ir4  [2];
  logic       ov4  [2];
  logic       err4 [2];
  logic [3:0] out4 [2];
  assign ir4[0]  = if1.i_ready;
  assign ir4[1]  = if2.i_ready;
  assign ov4[0]  = if1.o_valid;
  assign ov4[1]  = if2.o_valid;
  assign err4[0] = if1.o_err;
  assign err4[1] = if2.o_err;
  assign out4[0] = if1.o_out;
  assign out4[1] = if2.o_out;

  typedef struct {
    int         sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] n;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in4(input int sel, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] n);
    if (sel == 0) begin
      if1.i_valid = v; if1.i_a = a; if1.i_b = b; if1.i_modulus = n;
    end else begin
      if2.i_valid = v; if2.i_a = a; if2.i_b = b; if2.i_modulus = n;
    end
  endtask

  task automatic set_ordy4(input int sel, input logic v);
    if (sel == 0) if1.o_ready = v;
    else          if2.o_ready = v;
  endtask

  // Issue one request, count clock edges after the accepting edge until o_valid, then retire it.
  task automatic run_op4(input int sel, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] n, output logic [3:0] res,
                         output logic err, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ir4[sel] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("op4_ready_timeout", 512'(guard), 512'd0);
    set_in4(sel, 1'b1, a, b, n);
    @(posedge clk);
    #1 set_in4(sel, 1'b0, a, b, n);
    lat = 0;
    while (!ov4[sel] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out4[sel];
    err = err4[sel];
    set_ordy4(sel, 1'b1);
    @(posedge clk);
    #1 set_ordy4(sel, 1'b0);
  endtask

  task automatic run_op256(input logic [255:0] a, input logic [255:0] b,
                           input logic [255:0] n, output logic [255:0] res,
                           output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!if3.i_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("op256_ready_timeout", 512'(guard), 512'd0);
    if3.i_valid = 1'b1; if3.i_a = a; if3.i_b = b; if3.i_modulus = n;
    @(posedge clk);
    #1 if3.i_valid = 1'b0;
    lat = 0;
    while (!if3.o_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = if3.o_out;
    if3.o_ready = 1'b1;
    @(posedge clk);
    #1 if3.o_ready = 1'b0;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // res is the Montgomery product iff res < N and res * 2^256 == a*b (mod N).
  task automatic ref_check256(input logic [255:0] a, input logic [255:0] b,
                              input logic [255:0] n, input logic [255:0] res);
    logic [511:0] n5, r5, lhs, rhs;
    n5  = {256'd0, n};
    r5  = (512'd1 << 256) % n5;
    rhs = ({256'd0, a} * {256'd0, b}) % n5;
    lhs = ({256'd0, res} * r5) % n5;
    check("rnd_congruence", lhs, rhs);
    check("rnd_range", 512'((res < n) ? 1 : 0), 512'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   res4;
    logic         err;
    int           lat;
    int           guard;
    logic [255:0] ra, rb, rn, rres;

    vecs[0]  = '{0, 4'd5,  4'd7,  4'd13, 4'd3};
    vecs[1]  = '{0, 4'd12, 4'd12, 4'd13, 4'd9};
    vecs[2]  = '{0, 4'd1,  4'd1,  4'd13, 4'd9};
    vecs[3]  = '{0, 4'd0,  4'd7,  4'd13, 4'd0};
    vecs[4]  = '{0, 4'd3,  4'd5,  4'd15, 4'd0};
    vecs[5]  = '{0, 4'd12, 4'd1,  4'd13, 4'd4};
    vecs[6]  = '{0, 4'd7,  4'd7,  4'd13, 4'd12};
    vecs[7]  = '{0, 4'd14, 4'd14, 4'd15, 4'd1};
    vecs[8]  = '{1, 4'd12, 4'd12, 4'd13, 4'd9};
    vecs[9]  = '{1, 4'd1,  4'd1,  4'd13, 4'd9};
    vecs[10] = '{1, 4'd0,  4'd7,  4'd13, 4'd0};
    vecs[11] = '{1, 4'd3,  4'd5,  4'd15, 4'd0};
    vecs[12] = '{1, 4'd2,  4'd3,  4'd13, 4'd2};
    vecs[13] = '{1, 4'd5,  4'd7,  4'd13, 4'd3};

    set_in4(0, 1'b0, 4'd0, 4'd0, 4'd1);
    set_in4(1, 1'b0, 4'd0, 4'd0, 4'd1);
    set_ordy4(0, 1'b0);
    set_ordy4(1, 1'b0);
    if3.i_valid = 1'b0; if3.i_a = '0; if3.i_b = '0; if3.i_modulus = 256'd1; if3.o_ready = 1'b0;

    #2 rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_i_ready", 512'(ir4[s]), 512'd1);
      check("rst_o_valid", 512'(ov4[s]), 512'd0);
      check("rst_o_out", 512'(out4[s]), 512'd0);
      check("rst_o_err", 512'(err4[s]), 512'd0);
    end
    check("rst_w256_i_ready", 512'(if3.i_ready), 512'd1);
    check("rst_w256_o_valid", 512'(if3.o_valid), 512'd0);
    check("rst_w256_o_out", 512'(if3.o_out), 512'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op4(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].n, res4, err, lat);
      check($sformatf("vec%0d_out", i), 512'(res4), 512'(vecs[i].exp));
      check($sformatf("vec%0d_err", i), 512'(err), 512'd0);
      check($sformatf("vec%0d_lat", i), 512'(lat), 512'((vecs[i].sel == 0) ? 5 : 3));
    end

    // Result held in DONE while o_ready is low; a competing request must be ignored.
    @(negedge clk);
    set_in4(0, 1'b1, 4'd5, 4'd7, 4'd13);
    @(posedge clk);
    #1 set_in4(0, 1'b0, 4'd5, 4'd7, 4'd13);
    guard = 0;
    while (!ov4[0] && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("stall_enter_valid", 512'(ov4[0]), 512'd1);
    set_in4(0, 1'b1, 4'd1, 4'd1, 4'd13);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("stall_o_valid", 512'(ov4[0]), 512'd1);
      check("stall_o_out", 512'(out4[0]), 512'd3);
      check("stall_i_ready", 512'(ir4[0]), 512'd0);
    end
    set_in4(0, 1'b0, 4'd1, 4'd1, 4'd13);
    set_ordy4(0, 1'b1);
    @(posedge clk);
    #1 set_ordy4(0, 1'b0);
    check("release_o_valid", 512'(ov4[0]), 512'd0);
    check("release_i_ready", 512'(ir4[0]), 512'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check("release_no_extra", 512'(ov4[0]), 512'd0);
    end

    // Asynchronous reset in the middle of the loop.
    @(negedge clk);
    set_in4(0, 1'b1, 4'd5, 4'd7, 4'd13);
    @(posedge clk);
    #1 set_in4(0, 1'b0, 4'd5, 4'd7, 4'd13);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_i_ready", 512'(ir4[0]), 512'd1);
    check("midrst_o_valid", 512'(ov4[0]), 512'd0);
    check("midrst_o_out", 512'(out4[0]), 512'd0);
    @(posedge clk);
    #1 check("midrst_hold_o_valid", 512'(ov4[0]), 512'd0);
    @(negedge clk) rst = 1'b1;
    run_op4(0, 4'd5, 4'd7, 4'd13, res4, err, lat);
    check("after_rst_out", 512'(res4), 512'd3);
    check("after_rst_lat", 512'(lat), 512'd5);

`ifdef RSA_MONT_INPUT_CHECK_EN
    run_op4(0, 4'd1, 4'd1, 4'd12, res4, err, lat);
    check("chk_even_n_out", 512'(res4), 512'd0);
    check("chk_even_n_err", 512'(err), 512'd1);
    check("chk_even_n_lat", 512'(lat), 512'd0);
    run_op4(0, 4'd13, 4'd1, 4'd13, res4, err, lat);
    check("chk_a_big_out", 512'(res4), 512'd0);
    check("chk_a_big_err", 512'(err), 512'd1);
    check("chk_a_big_lat", 512'(lat), 512'd0);
    run_op4(0, 4'd5, 4'd7, 4'd13, res4, err, lat);
    check("chk_valid_out", 512'(res4), 512'd3);
    check("chk_valid_err", 512'(err), 512'd0);
    check("chk_valid_lat", 512'(lat), 512'd5);
`endif

    for (int i = 0; i < 1000; i++) begin
      rn = rnd256() | 256'd1;
      if (i % 2 == 1) rn[255] = 1'b1;
      ra = rnd256() % rn;
      rb = rnd256() % rn;
      if (i == 0) begin
        rn = '1;
        ra = rn - 256'd1;
        rb = rn - 256'd1;
      end
      if (i == 1) ra = '0;
      run_op256(ra, rb, rn, rres, lat);
      ref_check256(ra, rb, rn, rres);
      check("rnd_lat", 512'(lat), 512'd65);
      if (i == 1) check("rnd_zero_a", 512'(rres), 512'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
